// File: rtl/safe_mode_fsm_pkg.sv
// Shared types for the safe-mode sequencing FSM: state encoding, configuration
// encodings and the master-core index helper.
package safe_mode_fsm_pkg;

    localparam int NCORES_MAX = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BOOT      = 3'd1,
        RUN       = 3'd2,
        HALT_REQ  = 3'd3,
        SYNC_WAIT = 3'd4,
        RESUME    = 3'd5,
        ERROR     = 3'd6
    } state_e;

    localparam logic [1:0] CFG_TMR    = 2'b00;
    localparam logic [1:0] CFG_DMR    = 2'b01;
    localparam logic [1:0] CFG_SINGLE = 2'b10;

    // Index of a one-hot master select; anything that is not one-hot falls back to core 0.
    function automatic logic [1:0] master_index(input logic [NCORES_MAX-1:0] sel);
        logic [1:0] idx;
        case (sel)
            3'b001:  idx = 2'd0;
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/safe_core_mask_gen.sv
// Combinational core mask: which cores take part in a resync for the current
// redundancy configuration and master selection.
module safe_core_mask_gen
    import safe_mode_fsm_pkg::*;
(
    input  logic [NCORES_MAX-1:0] master_core_i,
    input  logic [1:0]            configuration_i,
    output logic [NCORES_MAX-1:0] mask_o
);

    logic [1:0] master_idx_s;

    assign master_idx_s = master_index(master_core_i);

    // DMR pairs the master with the next core modulo three.
    always_comb begin
        mask_o = 3'b000;
        case (configuration_i)
            CFG_TMR: mask_o = 3'b111;
            CFG_DMR: begin
                case (master_idx_s)
                    2'd0:    mask_o = 3'b011;
                    2'd1:    mask_o = 3'b110;
                    2'd2:    mask_o = 3'b101;
                    default: mask_o = 3'b011;
                endcase
            end
            default: mask_o = 3'b000;
        endcase
    end

endmodule

// File: rtl/safe_mode_fsm.sv
// Boot release and debug-mode resync sequencer for the TMR/DMR core cluster.
// Optional acknowledge timeout with sticky error: define SAFE_MODE_FSM_TIMEOUT_EN.
module safe_mode_fsm
    import safe_mode_fsm_pkg::*;
#(
    parameter int NCORES            = 3,
    parameter int BOOT_PULSE_CYCLES = 4,
    parameter int HALT_TIMEOUT      = 256
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [2:0]        master_core_i,
    input  logic              safe_mode_i,
    input  logic [1:0]        safe_configuration_i,
    input  logic              critical_section_i,
    input  logic              initial_sync_master_i,
    input  logic              start_i,
    input  logic              end_sw_routine_i,
    input  logic [NCORES-1:0] core_halted_i,
    output logic [NCORES-1:0] debug_req_o,
    output logic              start_boot_o,
    output logic              en_ext_debug_o,
    output logic              busy_o,
    output logic              error_o
);

    localparam int BOOT_W = (BOOT_PULSE_CYCLES > 1) ? $clog2(BOOT_PULSE_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LOAD = BOOT_W'(BOOT_PULSE_CYCLES - 1);

    if (NCORES != NCORES_MAX || BOOT_PULSE_CYCLES < 1 || HALT_TIMEOUT < 1 || HALT_TIMEOUT > 512) begin : g_bad_param
        $error("safe_mode_fsm: unsupported parameter combination");
    end

    state_e                state_r;
    logic [BOOT_W-1:0]     boot_cnt_r;
    logic [NCORES-1:0]     mask_r;
    logic [NCORES-1:0]     mask_s;
    logic                  start_q_r;
    logic                  sync_q_r;
    logic                  start_rise_s;
    logic                  sync_rise_s;
    logic [NCORES-1:0]     debug_req_r;
    logic                  start_boot_r;
    logic                  en_ext_debug_r;
    logic                  busy_r;
    logic                  error_r;
`ifdef SAFE_MODE_FSM_TIMEOUT_EN
    localparam logic [8:0] WAIT_LAST = 9'(HALT_TIMEOUT - 1);
    logic [8:0]            wait_cnt_r;
`endif

    safe_core_mask_gen u_mask_gen (
        .master_core_i   (master_core_i),
        .configuration_i (safe_configuration_i),
        .mask_o          (mask_s)
    );

    assign start_rise_s = start_i & ~start_q_r;
    assign sync_rise_s  = initial_sync_master_i & ~sync_q_r;

    // Edge-detect history for the start and resync request inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q_r <= 1'b0;
            sync_q_r  <= 1'b0;
        end else begin
            start_q_r <= start_i;
            sync_q_r  <= initial_sync_master_i;
        end
    end

    // Sequencer: state, counters, latched mask and registered outputs decoded from the current state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r        <= IDLE;
            boot_cnt_r     <= '0;
            mask_r         <= '0;
            debug_req_r    <= '0;
            start_boot_r   <= 1'b0;
            en_ext_debug_r <= 1'b0;
            busy_r         <= 1'b0;
            error_r        <= 1'b0;
`ifdef SAFE_MODE_FSM_TIMEOUT_EN
            wait_cnt_r     <= 9'd0;
`endif
        end else if (!start_i) begin
            // Abort beats everything, including a pending error.
            state_r        <= IDLE;
            boot_cnt_r     <= '0;
            mask_r         <= '0;
            debug_req_r    <= '0;
            start_boot_r   <= 1'b0;
            en_ext_debug_r <= 1'b0;
            busy_r         <= 1'b0;
            error_r        <= 1'b0;
`ifdef SAFE_MODE_FSM_TIMEOUT_EN
            wait_cnt_r     <= 9'd0;
`endif
        end else begin
            debug_req_r    <= '0;
            start_boot_r   <= 1'b0;
            en_ext_debug_r <= 1'b0;
            busy_r         <= (state_r != IDLE) && (state_r != RUN);
            error_r        <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_rise_s) begin
                        state_r    <= BOOT;
                        boot_cnt_r <= BOOT_LOAD;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                BOOT: begin
                    start_boot_r <= 1'b1;
                    if (boot_cnt_r == '0) begin
                        state_r    <= RUN;
                    end else begin
                        boot_cnt_r <= boot_cnt_r - BOOT_W'(1);
                    end
                end
                RUN: begin
                    if (sync_rise_s && safe_mode_i && critical_section_i && (mask_s != '0)) begin
                        state_r    <= HALT_REQ;
                        mask_r     <= mask_s;
`ifdef SAFE_MODE_FSM_TIMEOUT_EN
                        wait_cnt_r <= 9'd0;
`endif
                    end else begin
                        state_r    <= RUN;
                    end
                end
                HALT_REQ: begin
                    debug_req_r    <= mask_r;
                    en_ext_debug_r <= 1'b1;
                    if ((core_halted_i & mask_r) == mask_r) begin
                        state_r    <= SYNC_WAIT;
`ifdef SAFE_MODE_FSM_TIMEOUT_EN
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r    <= ERROR;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 9'd1;
`else
                    end else begin
                        state_r    <= HALT_REQ;
`endif
                    end
                end
                SYNC_WAIT: begin
                    debug_req_r    <= mask_r;
                    en_ext_debug_r <= 1'b1;
                    if (end_sw_routine_i) begin
                        state_r    <= RESUME;
`ifdef SAFE_MODE_FSM_TIMEOUT_EN
                        wait_cnt_r <= 9'd0;
`endif
                    end else begin
                        state_r    <= SYNC_WAIT;
                    end
                end
                RESUME: begin
                    if ((core_halted_i & mask_r) == '0) begin
                        state_r    <= RUN;
`ifdef SAFE_MODE_FSM_TIMEOUT_EN
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        state_r    <= ERROR;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 9'd1;
`else
                    end else begin
                        state_r    <= RESUME;
`endif
                    end
                end
                ERROR: begin
`ifdef SAFE_MODE_FSM_TIMEOUT_EN
                    error_r <= 1'b1;
                    state_r <= ERROR;
`else
                    state_r <= IDLE;
`endif
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign debug_req_o    = debug_req_r;
    assign start_boot_o   = start_boot_r;
    assign en_ext_debug_o = en_ext_debug_r;
    assign busy_o         = busy_r;
    assign error_o        = error_r;

endmodule
